// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg: shared state encoding and widths for lfsr_run_ctrl
// No ports. PAUSE encoding exists only when LFSR_RUN_CTRL_PAUSE_EN is defined.
package lfsr_ctrl_pkg;
  localparam int AN_W = 4;
  localparam int STEP_W = 16;
  localparam logic [AN_W-1:0] AN_RST = 4'b1110;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3
`ifdef LFSR_RUN_CTRL_PAUSE_EN
    , PAUSE = 3'd4
`endif
  } state_t;
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: 2-flop synchroniser plus rising-edge pulse for one pushbutton
// Ports: clock, reset (async active-low), btn (async input), pulse (one-cycle event).
// A button already high when reset releases never produces a pulse: the prior-sample
// flop is held at 1 until the synchroniser output carries a real sample.
module btn_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  logic s1, s2, prev;
  logic [1:0] vld;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b1;
      vld  <= 2'b00;
    end else begin
      s1   <= btn;
      s2   <= s1;
      vld  <= {vld[0], 1'b1};
      prev <= vld[1] ? s2 : 1'b1;
    end
  assign pulse = s2 & ~prev;
endmodule

// File: rtl/lfsr_run_ctrl.sv
// lfsr_run_ctrl: run controller for an external LFSR datapath with display scan
// Ports: clock, reset (async active-low), trigger/toggle (async buttons), lfsr_q (datapath value);
//        lfsr_load/lfsr_seed/lfsr_en (datapath control), step_cnt, an/digit_sel (digit scan), led1 (RUN), led2 (DONE).
// Macro LFSR_RUN_CTRL_PAUSE_EN enables the PAUSE state and the toggle path.
module lfsr_run_ctrl import lfsr_ctrl_pkg::*; #(
  parameter logic [7:0] SEED = 8'h01,
  parameter int RUN_LEN = 255,
  parameter int SCAN_DIV = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              trigger,
  input  logic              toggle,
  input  logic [7:0]        lfsr_q,
  output logic              lfsr_load,
  output logic [7:0]        lfsr_seed,
  output logic              lfsr_en,
  output logic [STEP_W-1:0] step_cnt,
  output logic [AN_W-1:0]   an,
  output logic [1:0]        digit_sel,
  output logic              led1,
  output logic              led2
);
  localparam logic [STEP_W-1:0] LAST = STEP_W'(RUN_LEN - 1);
  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  state_t state, nxt;
  logic [STEP_W-1:0] cnt_nxt;
  logic [15:0] div;
  logic trg;
  btn_edge_sync u_trg (.clock(clock), .reset(reset), .btn(trigger), .pulse(trg));
`ifdef LFSR_RUN_CTRL_PAUSE_EN
  logic tgl;
  btn_edge_sync u_tgl (.clock(clock), .reset(reset), .btn(toggle), .pulse(tgl));
`else
  logic unused_toggle;
  assign unused_toggle = toggle;
`endif
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      step_cnt <= '0;
    end else begin
      state    <= nxt;
      step_cnt <= cnt_nxt;
    end
  // RUN priority: lockup, then early stop, then terminal count, then pause.
  always_comb begin
    nxt     = state;
    cnt_nxt = step_cnt;
    case (state)
      IDLE: nxt = trg ? LOAD : IDLE;
      LOAD: nxt = RUN;
      RUN:
        if (lfsr_q == 8'h00) nxt = LOAD;
        else if (trg) nxt = DONE;
        else if (step_cnt == LAST) begin
          nxt     = DONE;
          cnt_nxt = step_cnt + 1'b1;
        end else begin
          cnt_nxt = step_cnt + 1'b1;
`ifdef LFSR_RUN_CTRL_PAUSE_EN
          nxt = tgl ? PAUSE : RUN;
`endif
        end
`ifdef LFSR_RUN_CTRL_PAUSE_EN
      PAUSE: nxt = trg ? DONE : tgl ? RUN : PAUSE;
`endif
      DONE: nxt = trg ? LOAD : DONE;
      default: nxt = IDLE;
    endcase
    if (nxt == LOAD) cnt_nxt = '0;
  end
  assign lfsr_load = state == LOAD;
  assign lfsr_en   = state == RUN;
  assign led1      = state == RUN;
  assign led2      = state == DONE;
  assign lfsr_seed = SEED;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      div       <= '0;
      digit_sel <= '0;
      an        <= AN_RST;
    end else if (div == DIV_LAST) begin
      div       <= '0;
      digit_sel <= digit_sel + 1'b1;
      an        <= {an[AN_W-2:0], an[AN_W-1]};
    end else begin
      div <= div + 1'b1;
    end
endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// tb_lfsr_run_ctrl: directed checks of lfsr_run_ctrl with RUN_LEN=10, SCAN_DIV=4
module tb_lfsr_run_ctrl;
  logic clock = 1'b0;
  logic reset, trigger, toggle;
  logic [7:0] lfsr_q;
  logic lfsr_load, lfsr_en, led1, led2;
  logic [7:0] lfsr_seed;
  logic [15:0] step_cnt;
  logic [3:0] an;
  logic [1:0] digit_sel;
  int n_chk = 0;
  int n_fail = 0;

  lfsr_run_ctrl #(.SEED(8'h01), .RUN_LEN(10), .SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset), .trigger(trigger), .toggle(toggle), .lfsr_q(lfsr_q),
    .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_en(lfsr_en), .step_cnt(step_cnt),
    .an(an), .digit_sel(digit_sel), .led1(led1), .led2(led2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic trig;
    logic load;
    logic en;
    logic [15:0] cnt;
    logic l1;
    logic l2;
  } vec_t;
  vec_t tbl[15];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {lfsr_load, lfsr_en, step_cnt, led1, led2};
  endfunction

  function automatic logic [19:0] ex(logic ld, logic en, logic [15:0] c, logic l1, logic l2);
    return {ld, en, c, l1, l2};
  endfunction

  task automatic press_trig();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic press_tgl();
    toggle = 1'b1;
    tick();
    toggle = 1'b0;
  endtask

  initial begin
    logic seen_load;
    reset = 1'b0;
    trigger = 1'b0;
    toggle = 1'b0;
    lfsr_q = 8'h5A;
    #12;
    chk("reset_outs", outs(), ex(0, 0, 0, 0, 0));
    chk("reset_an", {an, digit_sel}, {4'b1110, 2'd0});
    chk("seed", lfsr_seed, 8'h01);
    #8 reset = 1'b1;
    tick();

    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) tbl[3+i] = '{1'b0, 1'b0, 1'b1, 16'(i), 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'd10, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 16'd10, 1'b0, 1'b1};
    for (int i = 0; i < 15; i++) begin
      trigger = tbl[i].trig;
      tick();
      chk($sformatf("run_row%0d", i), outs(), ex(tbl[i].load, tbl[i].en, tbl[i].cnt, tbl[i].l1, tbl[i].l2));
    end

    press_trig();
    tick();
    tick();
    chk("restart_load", outs(), ex(1, 0, 0, 0, 0));
    tick();
    repeat (5) tick();
    chk("early_cnt5", outs(), ex(0, 1, 5, 1, 0));
    press_trig();
    tick();
    tick();
    chk("early_stop", outs(), ex(0, 0, 7, 0, 1));
    tick();
    chk("early_hold", outs(), ex(0, 0, 7, 0, 1));

    press_trig();
    tick();
    tick();
    tick();
    repeat (3) tick();
    chk("pre_lockup", outs(), ex(0, 1, 3, 1, 0));
    lfsr_q = 8'h00;
    tick();
    lfsr_q = 8'h5A;
    chk("lockup_load", outs(), ex(1, 0, 0, 0, 0));
    tick();
    chk("lockup_run", outs(), ex(0, 1, 0, 1, 0));
    tick();
    chk("lockup_cnt1", outs(), ex(0, 1, 1, 1, 0));

    press_tgl();
    tick();
    tick();
`ifdef LFSR_RUN_CTRL_PAUSE_EN
    chk("pause_enter", outs(), ex(0, 0, 4, 0, 0));
    tick();
    chk("pause_hold", outs(), ex(0, 0, 4, 0, 0));
    press_tgl();
    tick();
    tick();
    chk("pause_resume", outs(), ex(0, 1, 4, 1, 0));
    tick();
    chk("resume_count", outs(), ex(0, 1, 5, 1, 0));
`else
    chk("tgl_ignored", outs(), ex(0, 1, 4, 1, 0));
    tick();
    chk("tgl_count", outs(), ex(0, 1, 5, 1, 0));
    press_tgl();
    tick();
    tick();
    chk("tgl_ignored2", outs(), ex(0, 1, 8, 1, 0));
`endif

    reset = 1'b0;
    #1;
    chk("midrun_reset", outs(), ex(0, 0, 0, 0, 0));
    chk("midrun_an", {an, digit_sel}, {4'b1110, 2'd0});
    trigger = 1'b1;
    #2 reset = 1'b1;
    seen_load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen_load |= lfsr_load | led1;
    end
    chk("held_no_event", {seen_load, outs()}, {1'b0, ex(0, 0, 0, 0, 0)});
    trigger = 1'b0;
    repeat (2) tick();
    press_trig();
    tick();
    tick();
    chk("fresh_trigger", outs(), ex(1, 0, 0, 0, 0));

    reset = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("scan_0", {an, digit_sel}, {4'b1110, 2'd0});
    tick();
    chk("scan_1", {an, digit_sel}, {4'b1101, 2'd1});
    repeat (4) tick();
    chk("scan_2", {an, digit_sel}, {4'b1011, 2'd2});
    repeat (4) tick();
    chk("scan_3", {an, digit_sel}, {4'b0111, 2'd3});
    repeat (4) tick();
    chk("scan_wrap", {an, digit_sel}, {4'b1110, 2'd0});
    repeat (6) tick();
    chk("scan_mid", {an, digit_sel}, {4'b1101, 2'd1});
    reset = 1'b0;
    #1;
    chk("scan_reset", {an, digit_sel}, {4'b1110, 2'd0});
    reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
